// File: rtl/cordic_div_pkg.sv
// Shared types and defaults for the linear-vectoring CORDIC divider.
package cordic_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  localparam int DEF_ITER       = 8;
  localparam int DEF_RES_W      = 18;
  localparam int DEF_APPROX_LSB = 4;

  localparam int Q_MAX = 127;
  localparam int Q_MIN = -128;

endpackage

// File: rtl/approx_adder_loa.sv
// Residual adder: exact, or lower-part-OR approximate when APPROX_ADDER_EN is defined.
// The low L bits are OR-ed; their top bit pair generates the carry into the exact upper part.
module approx_adder_loa #(
  parameter int W = 18,
  parameter int L = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

`ifdef APPROX_ADDER_EN
  localparam bit LOA_ON = 1'b1;
`else
  localparam bit LOA_ON = 1'b0;
`endif

  generate
    if (!LOA_ON || L == 0) begin : g_exact
      assign sum = a + b;
    end else begin : g_loa
      logic carry;
      assign carry        = a[L-1] & b[L-1];
      assign sum[L-1:0]   = a[L-1:0] | b[L-1:0];
      assign sum[W-1:L]   = a[W-1:L] + b[W-1:L] + {{(W-L-1){1'b0}}, carry};
    end
  endgenerate

endmodule

// File: rtl/cordic_divider_approx.sv
// Iterative linear-vectoring CORDIC divider: z = trunc(y / x), saturated to 8 bits.
// Optional approximate residual adder enabled with `define APPROX_ADDER_EN.
module cordic_divider_approx
  import cordic_div_pkg::*;
#(
  parameter int ITER       = DEF_ITER,
  parameter int RES_W      = DEF_RES_W,
  parameter int APPROX_LSB = DEF_APPROX_LSB
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [15:0] y,
  input  logic signed [7:0]  x,
  output logic signed [7:0]  z,
  output logic               done,
  output logic               busy,
  output logic               ovf
);

  localparam int ACC_W = ITER + 2;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  localparam logic signed [ACC_W-1:0] ACC_QMAX   = ACC_W'(Q_MAX);
  localparam logic signed [ACC_W-1:0] ACC_QMIN   = ACC_W'(Q_MIN);
  // Divide-by-zero preloads acc with a value that is guaranteed to saturate.
  localparam logic signed [ACC_W-1:0] ACC_DZ_POS = ACC_W'((1 << ITER) - 1);
  localparam logic signed [ACC_W-1:0] ACC_DZ_NEG = ACC_W'(-(1 << ITER));

  state_t                   state, state_nxt;
  logic signed [RES_W-1:0]  r;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         i;
  logic signed [7:0]        x_q;
  logic                     y_neg;

  logic [CNT_W-1:0]         shamt;
  logic signed [RES_W-1:0]  x_ext, x_shift, step_b, r_sum;
  logic signed [ACC_W-1:0]  acc_step, acc_run, acc_fix;
  logic                     d_pos, fix_en, fix_up, r_is_x;
  logic                     sat_hi, sat_lo;
  logic signed [7:0]        z_sat;

  assign shamt    = LAST - i;
  assign x_ext    = {{(RES_W-8){x_q[7]}}, x_q};
  assign x_shift  = x_ext <<< shamt;
  assign d_pos    = (r[RES_W-1] == x_q[7]);
  assign step_b   = d_pos ? -x_shift : x_shift;
  assign acc_step = ACC_W'(1) << shamt;
  assign acc_run  = d_pos ? acc + acc_step : acc - acc_step;

  approx_adder_loa #(
    .W(RES_W),
    .L(APPROX_LSB)
  ) u_res_add (
    .a  (r),
    .b  (step_b),
    .sum(r_sum)
  );

  // The final residual lies in [-|x|, |x|]; a residual of the wrong sign, or one
  // equal to +-x, means the quotient is one unit away from truncation.
  assign r_is_x  = (r == x_ext) || (r == -x_ext);
  assign fix_en  = (|r) && ((r[RES_W-1] != y_neg) || r_is_x);
  assign fix_up  = (r[RES_W-1] == x_q[7]);
  assign acc_fix = fix_up ? acc + ACC_W'(1) : acc - ACC_W'(1);

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    sat_hi = (acc > ACC_QMAX);
    sat_lo = (acc < ACC_QMIN);
    z_sat  = acc[7:0];
    if (sat_hi) begin
      z_sat = 8'(Q_MAX);
    end else if (sat_lo) begin
      z_sat = 8'(Q_MIN);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (x == '0) ? DONE : RUN;
      RUN:     if (i == LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // NOTE: every datapath register is cleared by reset, so an abandoned run leaves no stale operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r     <= '0;
      acc   <= '0;
      i     <= '0;
      x_q   <= '0;
      y_neg <= 1'b0;
      z     <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_q   <= x;
            y_neg <= y[15];
            r     <= {{(RES_W-16){y[15]}}, y};
            i     <= '0;
            if (x == '0) begin
              acc <= y[15] ? ACC_DZ_NEG : ACC_DZ_POS;
            end else begin
              acc <= '0;
            end
          end
        end
        RUN: begin
          r   <= r_sum;
          acc <= acc_run;
          i   <= i + CNT_W'(1);
        end
        FIX: begin
          if (fix_en) acc <= acc_fix;
        end
        DONE: begin
          z    <= z_sat;
          ovf  <= sat_hi | sat_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_divider_approx.sv
// Self-checking bench for cordic_divider_approx: directed vectors, reset, back-to-back and a sweep.
// With APPROX_ADDER_EN defined the sweep reports approximation error statistics instead of exact checks.
module tb_cordic_divider_approx;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic signed [15:0] y = '0;
  logic signed [7:0]  x = '0;
  logic signed [7:0]  z;
  logic               done, busy, ovf;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int y;
    int x;
    int z;
    int ovf;
    int lat;
  } vec_t;

  cordic_divider_approx dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .y    (y),
    .x    (x),
    .z    (z),
    .done (done),
    .busy (busy),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One division; lat counts edges from the accepting edge to the edge raising done.
  task automatic run_div(input int yv, input int xv, output int zo, output int ov,
                         output int lat, output int busy_acc, output int busy_done);
    @(negedge clk);
    y = 16'(yv);
    x = 8'(xv);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_acc = int'(busy);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    zo = int'(z);
    ov = int'(ovf);
    busy_done = int'(busy);
  endtask

  vec_t vecs [14];
  int   zo, ov, lat, b_acc, b_done;
  int   x_list[$], z_list[$];
  int   pulses, n_pulse;
  int   t_pulse[3];
  int   z_pulse[3];
  int   err, max_err, sum_err, n_big, n_runs;

  initial begin
    #1000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{1000,   10,  100, 0, 10},
      '{-1000,  10, -100, 0, 10},
      '{1005,  -10, -100, 0, 10},
      '{7,       2,    3, 0, 10},
      '{-7,      2,   -3, 0, 10},
      '{0,      10,    0, 0, 10},
      '{-20,    10,   -2, 0, 10},
      '{128,     1,  127, 1, 10},
      '{-128,    1, -128, 0, 10},
      '{16384, -128, -128, 0, 10},
      '{16000,  10,  127, 1, 10},
      '{-16000, 10, -128, 1, 10},
      '{500,     0,  127, 1, 1},
      '{-500,    0, -128, 1, 1}
    };

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset z", int'(z), 0);
    check("reset done", int'(done), 0);
    check("reset busy", int'(busy), 0);
    check("reset ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    foreach (vecs[k]) begin
      run_div(vecs[k].y, vecs[k].x, zo, ov, lat, b_acc, b_done);
`ifdef APPROX_ADDER_EN
      if (vecs[k].x == 0)
`endif
      check($sformatf("z y=%0d x=%0d", vecs[k].y, vecs[k].x), zo, vecs[k].z);
`ifdef APPROX_ADDER_EN
      if (vecs[k].x == 0)
`endif
      check($sformatf("ovf y=%0d x=%0d", vecs[k].y, vecs[k].x), ov, vecs[k].ovf);
      check($sformatf("latency y=%0d x=%0d", vecs[k].y, vecs[k].x), lat, vecs[k].lat);
      check($sformatf("busy at accept y=%0d", vecs[k].y), b_acc, 1);
      check($sformatf("busy at done y=%0d", vecs[k].y), b_done, 0);
      if (k == 0) begin
        @(posedge clk);
        #1;
        check("done single pulse", int'(done), 0);
        repeat (2) @(posedge clk);
        #1;
        check("z held after done", int'(z), vecs[0].z);
      end
    end

    // Reset in the middle of a computation
    @(negedge clk);
    y = 16'(1000);
    x = 8'(10);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("busy mid run", int'(busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset busy", int'(busy), 0);
    check("mid reset z", int'(z), 0);
    check("mid reset ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("no done after reset", pulses, 0);

    // Start held high: back-to-back results
    @(negedge clk);
    y = 16'(1000);
    x = 8'(10);
    start = 1'b1;
    n_pulse = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done && n_pulse < 3) begin
        t_pulse[n_pulse] = cyc;
        z_pulse[n_pulse] = int'(z);
        n_pulse++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("b2b pulse count", n_pulse, 3);
    if (n_pulse == 3) begin
      check("b2b interval 1", t_pulse[1] - t_pulse[0], 11);
      check("b2b interval 2", t_pulse[2] - t_pulse[1], 11);
`ifndef APPROX_ADDER_EN
      check("b2b z 2", z_pulse[1], 100);
      check("b2b z 3", z_pulse[2], 100);
`endif
    end
    repeat (12) @(posedge clk);

    // Sweep of y = x*z over a spread of divisors and quotients
    for (int xi = -128; xi <= 127; xi += 9) x_list.push_back(xi);
    x_list.push_back(127);
    x_list.push_back(-1);
    x_list.push_back(1);
    for (int zi = -128; zi <= 127; zi += 7) z_list.push_back(zi);
    z_list.push_back(127);
    z_list.push_back(-1);
    z_list.push_back(0);
    z_list.push_back(1);
    max_err = 0;
    sum_err = 0;
    n_big = 0;
    n_runs = 0;
    foreach (x_list[a]) begin
      foreach (z_list[b]) begin
        run_div(x_list[a] * z_list[b], x_list[a], zo, ov, lat, b_acc, b_done);
        n_runs++;
`ifdef APPROX_ADDER_EN
        err = (zo > z_list[b]) ? zo - z_list[b] : z_list[b] - zo;
        if (err > max_err) max_err = err;
        sum_err += err;
        if (err * 100 > 5 * ((z_list[b] < 0) ? -z_list[b] : z_list[b])) n_big++;
`else
        check($sformatf("sweep z y=%0d x=%0d", x_list[a] * z_list[b], x_list[a]), zo, z_list[b]);
        check($sformatf("sweep ovf y=%0d x=%0d", x_list[a] * z_list[b], x_list[a]), ov, 0);
`endif
      end
    end
`ifdef APPROX_ADDER_EN
    $display("approx sweep: %0d runs, max err %0d, avg err %0.3f, %0d runs above 5%% relative error",
             n_runs, max_err, real'(sum_err) / real'(n_runs), n_big);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
